id_ctl_pipe: RTL and testbench

//  ID-stage control unit with registered ID/EX control: decodes opcode to WB/M/EX control words,

---
 rtl/mips_ctl_pkg.sv | 20 ++
 rtl/ctl_decode.sv | 68 ++++++
 rtl/id_ctl_pipe.sv | 100 ++++++++++
 tb/tb_id_ctl_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctl_pkg.sv
// Shared opcode constants, control-word widths and FSM state type for the ID-stage
// control pipeline.
package mips_ctl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } state_t;

endpackage

// File: rtl/ctl_decode.sv
// Pure combinational opcode decoder producing the WB/M/EX control words and the
// register-usage flags consumed by the load-use hazard check.
module ctl_decode
  import mips_ctl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic            id_valid,
  input  logic [5:0]      opcode,
  output logic [WB_W-1:0] ctl_wb,
  output logic [M_W-1:0]  ctl_m,
  output logic [EX_W-1:0] ctl_ex,
  output logic            uses_rs,
  output logic            uses_rt
);

  // Unknown opcodes and empty slots decode to an all-zero word that touches no registers.
  always_comb begin
    ctl_wb  = '0;
    ctl_m   = '0;
    ctl_ex  = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (id_valid) begin
      case (opcode)
        OP_RTYPE: begin
          ctl_wb  = 2'b10;
          ctl_m   = 3'b000;
          ctl_ex  = 4'b1100;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_LW: begin
          ctl_wb  = 2'b11;
          ctl_m   = 3'b010;
          ctl_ex  = 4'b0001;
          uses_rs = 1'b1;
        end
        OP_SW: begin
          ctl_wb  = 2'b00;
          ctl_m   = 3'b001;
          ctl_ex  = 4'b0001;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_BEQ: begin
          ctl_wb  = 2'b00;
          ctl_m   = 3'b100;
          ctl_ex  = 4'b0010;
          uses_rs = 1'b1;
          uses_rt = 1'b1;
        end
        OP_ADDI: begin
          if (EXT_OPS != 0) begin
            ctl_wb  = 2'b10;
            ctl_m   = 3'b000;
            ctl_ex  = 4'b0001;
            uses_rs = 1'b1;
          end
        end
        default: begin
          ctl_wb = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ctl_pipe.sv
// ID-stage control unit: decode, load-use stall FSM, branch flush, registered ID/EX
// control word and a saturating bubble counter.
module id_ctl_pipe
  import mips_ctl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int EXT_OPS    = 1,
  parameter int PCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_flush,
  output logic [WB_W-1:0]   ex_ctlwb,
  output logic [M_W-1:0]    ex_ctlm,
  output logic [EX_W-1:0]   ex_ctlex,
  output logic [4:0]        ex_rt,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [PCNT_W-1:0] bubble_cnt
);

  logic [WB_W-1:0] dec_wb;
  logic [M_W-1:0]  dec_m;
  logic [EX_W-1:0] dec_ex;
  logic            uses_rs;
  logic            uses_rt;
  logic            hazard;
  logic            stall;
  logic            do_bubble;
  state_t          state;
  logic [1:0]      cnt;

  ctl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .id_valid (id_valid),
    .opcode   (opcode),
    .ctl_wb   (dec_wb),
    .ctl_m    (dec_m),
    .ctl_ex   (dec_ex),
    .uses_rs  (uses_rs),
    .uses_rt  (uses_rt)
  );

  // A load in EX whose destination feeds the ID instruction must not be bypassed yet.
  always_comb begin
    hazard = id_valid & ex_ctlm[1] & (ex_rt != 5'd0) &
             ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));
    stall      = ((state == ST_RUN) & hazard & ~ex_flush) | ((state == ST_STALL) & ~ex_flush);
    do_bubble  = ex_flush | (state == ST_STALL) | hazard;
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  // cnt holds the bubbles still owed after the one being inserted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else if (ex_flush) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else if (state == ST_STALL) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) state <= ST_RUN;
    end else if (hazard && (LOAD_STALL > 1)) begin
      state <= ST_STALL;
      cnt   <= 2'(LOAD_STALL - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      ex_ctlwb <= '0;
      ex_ctlm  <= '0;
      ex_ctlex <= '0;
      ex_rt    <= 5'd0;
      ex_valid <= 1'b0;
    end else begin
      ex_ctlwb <= dec_wb;
      ex_ctlm  <= dec_m;
      ex_ctlex <= dec_ex;
      ex_rt    <= id_rt;
      ex_valid <= id_valid;
    end
  end

  // Only hazard-driven bubbles are counted; flushes and empty slots are not stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (stall && (bubble_cnt != {PCNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + PCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ctl_pipe.sv
// Bench for id_ctl_pipe: three parameterisations share one input stream and are compared
// every cycle against a remaining-bubbles reference model, plus directed scenario checks.
module tb_id_ctl_pipe;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [5:0] opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_flush;

  logic [1:0]  wb  [3];
  logic [2:0]  m   [3];
  logic [3:0]  ex  [3];
  logic [4:0]  ert [3];
  logic        ev  [3];
  logic        pcw [3];
  logic        ifw [3];
  logic [15:0] bc  [3];
  logic [1:0]  bc_small;

  logic [1:0] mwb  [3];
  logic [2:0] mm   [3];
  logic [3:0] mex  [3];
  logic [4:0] mrt  [3];
  logic       mev  [3];
  int         left [3];
  int         mbc  [3];
  logic       pcw_seen [3];

  int total;
  int bad;

  id_ctl_pipe #(.LOAD_STALL(1), .EXT_OPS(1), .PCNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_flush(ex_flush), .ex_ctlwb(wb[0]), .ex_ctlm(m[0]), .ex_ctlex(ex[0]), .ex_rt(ert[0]),
    .ex_valid(ev[0]), .pc_write(pcw[0]), .ifid_write(ifw[0]), .bubble_cnt(bc[0])
  );

  id_ctl_pipe #(.LOAD_STALL(3), .EXT_OPS(1), .PCNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_flush(ex_flush), .ex_ctlwb(wb[1]), .ex_ctlm(m[1]), .ex_ctlex(ex[1]), .ex_rt(ert[1]),
    .ex_valid(ev[1]), .pc_write(pcw[1]), .ifid_write(ifw[1]), .bubble_cnt(bc_small)
  );

  id_ctl_pipe #(.LOAD_STALL(2), .EXT_OPS(0), .PCNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_flush(ex_flush), .ex_ctlwb(wb[2]), .ex_ctlm(m[2]), .ex_ctlex(ex[2]), .ex_rt(ert[2]),
    .ex_valid(ev[2]), .pc_write(pcw[2]), .ifid_write(ifw[2]), .bubble_cnt(bc[2])
  );

  assign bc[1] = {14'd0, bc_small};

  always #5 clk = ~clk;

  function automatic int lsOf(int i);
    if (i == 0) return 1;
    if (i == 1) return 3;
    return 2;
  endfunction

  function automatic int cntMax(int i);
    if (i == 1) return 3;
    return 65535;
  endfunction

  // Returns {wb[1:0], m[2:0], ex[3:0], uses_rs, uses_rt} straight from the opcode table.
  function automatic logic [10:0] refDecode(logic v, logic [5:0] op, bit ext);
    if (!v) return 11'd0;
    case (op)
      6'h00:   return {2'b10, 3'b000, 4'b1100, 1'b1, 1'b1};
      6'h23:   return {2'b11, 3'b010, 4'b0001, 1'b1, 1'b0};
      6'h2b:   return {2'b00, 3'b001, 4'b0001, 1'b1, 1'b1};
      6'h04:   return {2'b00, 3'b100, 4'b0010, 1'b1, 1'b1};
      6'h08:   return ext ? {2'b10, 3'b000, 4'b0001, 1'b1, 1'b0} : 11'd0;
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic modelHazard(int i);
    logic [10:0] d;
    d = refDecode(id_valid, opcode, i != 2);
    return id_valid && mm[i][1] && (mrt[i] != 5'd0) &&
           ((d[1] && mrt[i] == id_rs) || (d[0] && mrt[i] == id_rt));
  endfunction

  function automatic logic modelStall(int i);
    return !ex_flush && (left[i] > 0 || modelHazard(i));
  endfunction

  task automatic modelBubble(int i);
    mwb[i] = 2'd0;
    mm[i]  = 3'd0;
    mex[i] = 4'd0;
    mrt[i] = 5'd0;
    mev[i] = 1'b0;
  endtask

  task automatic modelUpdate(int i);
    logic        haz;
    logic [10:0] d;
    haz = modelHazard(i);
    d   = refDecode(id_valid, opcode, i != 2);
    if (rst) begin
      modelBubble(i);
      left[i] = 0;
      mbc[i]  = 0;
    end else if (ex_flush) begin
      modelBubble(i);
      left[i] = 0;
    end else if (left[i] > 0 || haz) begin
      left[i] = (left[i] > 0) ? left[i] - 1 : lsOf(i) - 1;
      modelBubble(i);
      if (mbc[i] < cntMax(i)) mbc[i]++;
    end else begin
      mwb[i] = d[10:9];
      mm[i]  = d[8:6];
      mex[i] = d[5:2];
      mrt[i] = id_rt;
      mev[i] = id_valid;
    end
  endtask

  task automatic checkOutput(int i);
    logic [16:0] obs;
    logic [16:0] exp;
    logic        st;
    st  = modelStall(i);
    obs = {wb[i], m[i], ex[i], ert[i], ev[i], pcw[i], ifw[i]};
    exp = {mwb[i], mm[i], mex[i], mrt[i], mev[i], ~st, ~st};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL ctl inst%0d observed=%h expected=%h", i, obs, exp);
    end
    total++;
    assert (bc[i] === 16'(mbc[i])) else begin
      bad++;
      $error("[TB] FAIL bubble_cnt inst%0d observed=%0d expected=%0d", i, bc[i], mbc[i]);
    end
  endtask

  task automatic checkConst(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                               logic fl, logic r);
    id_valid = v;
    opcode   = op;
    id_rs    = rs;
    id_rt    = rt;
    ex_flush = fl;
    rst      = r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput(i);
      pcw_seen[i] = pcw[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelUpdate(i);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    id_valid = 1'b0;
    opcode   = 6'h00;
    id_rs    = 5'd0;
    id_rt    = 5'd0;
    ex_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      modelBubble(i);
      left[i] = 0;
      mbc[i]  = 0;
      pcw_seen[i] = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    doReset();
    checkConst("reset word", 16'({wb[0], m[0], ex[0]}), 16'd0);
    checkConst("reset rt/valid", 16'({ert[1], ev[1]}), 16'd0);
    checkConst("reset bubble_cnt", bc[0], 16'd0);

    // Back-to-back R, LW, SW, BEQ with no register overlap.
    applyStimulus(1'b1, 6'h00, 5'd1, 5'd2, 1'b0, 1'b0);
    checkConst("t1 r word", 16'({wb[0], m[0], ex[0]}), 16'({2'b10, 3'b000, 4'b1100}));
    applyStimulus(1'b1, 6'h23, 5'd3, 5'd9, 1'b0, 1'b0);
    checkConst("t1 lw word", 16'({wb[0], m[0], ex[0]}), 16'({2'b11, 3'b010, 4'b0001}));
    applyStimulus(1'b1, 6'h2b, 5'd4, 5'd10, 1'b0, 1'b0);
    checkConst("t1 sw pc_write", 16'(pcw_seen[0]), 16'd1);
    checkConst("t1 sw word", 16'({wb[0], m[0], ex[0]}), 16'({2'b00, 3'b001, 4'b0001}));
    applyStimulus(1'b1, 6'h04, 5'd5, 5'd11, 1'b0, 1'b0);
    checkConst("t1 beq word", 16'({wb[0], m[0], ex[0]}), 16'({2'b00, 3'b100, 4'b0010}));
    checkConst("t1 beq rt", 16'(ert[0]), 16'd11);

    // Load-use on rs with a single bubble.
    doReset();
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h00, 5'd5, 5'd6, 1'b0, 1'b0);
    checkConst("t2 stall pc_write", 16'(pcw_seen[0]), 16'd0);
    checkConst("t2 bubble valid", 16'(ev[0]), 16'd0);
    checkConst("t2 bubble_cnt", bc[0], 16'd1);
    applyStimulus(1'b1, 6'h00, 5'd5, 5'd6, 1'b0, 1'b0);
    checkConst("t2 issue pc_write", 16'(pcw_seen[0]), 16'd1);
    checkConst("t2 issue word", 16'({ev[0], wb[0], m[0], ex[0]}), 16'({1'b1, 2'b10, 3'b000, 4'b1100}));

    // r0 destination and unused rt never stall.
    doReset();
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
    checkConst("t3 r0 pc_write", 16'(pcw_seen[1]), 16'd1);
    applyStimulus(1'b1, 6'h23, 5'd2, 5'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h23, 5'd3, 5'd7, 1'b0, 1'b0);
    checkConst("t3 lw rt pc_write", 16'(pcw_seen[1]), 16'd1);
    checkConst("t3 bubble_cnt", bc[1], 16'd0);

    // Three-bubble stall on rt, then a second stall to saturate the 2-bit counter.
    doReset();
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b0);
      checkConst($sformatf("t4 pc_write cycle%0d", k), 16'(pcw_seen[1]), (k < 3) ? 16'd0 : 16'd1);
    end
    checkConst("t4 beq issued", 16'(m[1]), 16'(3'b100));
    checkConst("t4 bubble_cnt", bc[1], 16'd3);
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd6, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 6'h00, 5'd6, 5'd1, 1'b0, 1'b0);
    checkConst("t4 saturated", bc[1], 16'd3);
    checkConst("t4 ls1 count", bc[0], 16'd2);

    // Flush in the second stall cycle ends the stall at once.
    doReset();
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b1, 1'b0);
    checkConst("t5 flush pc_write", 16'(pcw_seen[1]), 16'd1);
    checkConst("t5 flush valid", 16'(ev[1]), 16'd0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b0);
    checkConst("t5 resume pc_write", 16'(pcw_seen[1]), 16'd1);
    checkConst("t5 bubble_cnt", bc[1], 16'd1);

    // Reset during a stall, then ADDI with and without the extension.
    doReset();
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b1);
    checkConst("t6 reset word", 16'({wb[1], m[1], ex[1], ev[1]}), 16'd0);
    checkConst("t6 reset cnt", bc[1], 16'd0);
    applyStimulus(1'b1, 6'h04, 5'd2, 5'd4, 1'b0, 1'b0);
    checkConst("t6 after reset pc_write", 16'(pcw_seen[1]), 16'd1);
    applyStimulus(1'b1, 6'h08, 5'd1, 5'd2, 1'b0, 1'b0);
    checkConst("t6 addi ext0", 16'({wb[2], m[2], ex[2]}), 16'd0);
    checkConst("t6 addi ext0 valid", 16'(ev[2]), 16'd1);
    checkConst("t6 addi ext1", 16'({wb[0], m[0], ex[0]}), 16'({2'b10, 3'b000, 4'b0001}));

    // Random traffic with small register numbers so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h23;
        3: op = 6'h2b;
        4: op = 6'h04;
        default: op = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
